// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder
// Registered ALU decoder between decode and the scalar/vector ALUs. Turns
// Opcode/Func/ALUOp into ALUControl/FlagWrite and, for vector ops, splits the
// op into NUM_GROUPS beats when the vector ALU is narrower than the register.
//
// Handshake: an input op is taken on a rising edge where in_valid & in_ready.
// An output beat is consumed on a rising edge where out_valid & out_ready;
// while out_valid & !out_ready every output field is held stable.
module alu_issue_decoder #(
    parameter int VEC_LANES       = 16,
    parameter int LANES_PER_CYCLE = 4,
    localparam int NUM_GROUPS     = VEC_LANES / LANES_PER_CYCLE,
    localparam int GW             = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    Opcode,
    input  logic [2:0]    Func,
    input  logic          ALUOp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    ALUControl,
    output logic [1:0]    FlagWrite,
    output logic          IsVector,
    output logic [GW-1:0] LaneGroup,
    output logic          LaneFirst,
    output logic          LaneLast,
    output logic          IllegalOp,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,   // no beat pending
        S_VEC   = 2'd1,   // vector op, non-final beat pending
        S_HOLD  = 2'd2    // final (or only) beat pending
    } state_t;

    localparam logic          MULTI_OK = (NUM_GROUPS > 1);
    localparam logic [GW-1:0] LAST_G   = GW'(NUM_GROUPS - 1);

    state_t        state_q, state_n;
    logic [2:0]    dec_ctl;
    logic          dec_vec, dec_ill, dec_multi;
    logic          accept;
    logic [GW-1:0] grp_inc;
    logic          reaching_last;

    logic          valid_n, isv_n, first_n, last_n, ill_n;
    logic [2:0]    ctl_n;
    logic [1:0]    fw_n;
    logic [GW-1:0] grp_n;

    assign in_ready      = !out_valid | (out_ready & LaneLast);
    assign accept        = in_valid & in_ready;
    assign dec_multi     = dec_vec & MULTI_OK;
    assign grp_inc       = LaneGroup + GW'(1);
    assign reaching_last = (grp_inc == LAST_G);
    assign state_dbg     = state_q;

    // Decode the incoming encoding; illegal encodings leave ALUControl at add.
    always_comb begin
        dec_ctl = 3'b000;
        dec_vec = 1'b0;
        dec_ill = 1'b0;
        if (ALUOp) begin
            case (Opcode)
                6'b000000: begin
                    case (Func)
                        3'b100, 3'b110: dec_ill = 1'b1;
                        default:        dec_ctl = Func;
                    endcase
                end
                6'b100000: begin
                    case (Func)
                        3'b000, 3'b001, 3'b010, 3'b101: begin
                            dec_ctl = Func;
                            dec_vec = 1'b1;
                        end
                        default: dec_ill = 1'b1;
                    endcase
                end
                6'b001000: dec_ctl = 3'b000;
                6'b001001: dec_ctl = 3'b001;
                6'b001010: dec_ctl = 3'b010;
                6'b000100: dec_ctl = 3'b001;   // branch compares by subtracting
                default:   dec_ctl = 3'b000;
            endcase
        end
    end

    // State register; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_EMPTY;
        else       state_q <= state_n;
    end

    // Next-state logic; flush beats any simultaneous accept.
    always_comb begin
        state_n = state_q;
        if (flush) begin
            state_n = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (accept) state_n = dec_multi ? S_VEC : S_HOLD;
                S_VEC:   if (out_ready && reaching_last) state_n = S_HOLD;
                S_HOLD: begin
                    if (out_ready) begin
                        if (accept) state_n = dec_multi ? S_VEC : S_HOLD;
                        else        state_n = S_EMPTY;
                    end
                end
                default: state_n = S_EMPTY;
            endcase
        end
    end

    // Next values of the registered beat fields.
    always_comb begin
        valid_n = out_valid;
        ctl_n   = ALUControl;
        fw_n    = FlagWrite;
        isv_n   = IsVector;
        grp_n   = LaneGroup;
        first_n = LaneFirst;
        last_n  = LaneLast;
        ill_n   = IllegalOp;
        if (flush) begin
            valid_n = 1'b0;
            grp_n   = '0;
        end else if ((state_q == S_EMPTY && accept) ||
                     (state_q == S_HOLD && out_ready && accept)) begin
            // Load the first beat of a new op (back-to-back from HOLD).
            valid_n = 1'b1;
            ctl_n   = dec_ctl;
            isv_n   = dec_vec;
            grp_n   = '0;
            first_n = 1'b1;
            last_n  = !dec_multi;
            fw_n    = (dec_ill || dec_multi) ? 2'b00 : 2'b11;
            ill_n   = dec_ill;
        end else if (state_q == S_VEC && out_ready) begin
            grp_n   = grp_inc;
            first_n = 1'b0;
            if (reaching_last) begin
                last_n = 1'b1;
                fw_n   = 2'b11;
            end
        end else if (state_q == S_HOLD && out_ready) begin
            valid_n = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            ALUControl <= 3'b000;
            FlagWrite  <= 2'b00;
            IsVector   <= 1'b0;
            LaneGroup  <= '0;
            LaneFirst  <= 1'b0;
            LaneLast   <= 1'b0;
            IllegalOp  <= 1'b0;
        end else begin
            out_valid  <= valid_n;
            ALUControl <= ctl_n;
            FlagWrite  <= fw_n;
            IsVector   <= isv_n;
            LaneGroup  <= grp_n;
            LaneFirst  <= first_n;
            LaneLast   <= last_n;
            IllegalOp  <= ill_n;
        end
    end

endmodule
